// File: rtl/vga_pkg.sv
// 640x480@60 VGA timing constants, RGB111 colour type and the per-pixel flag
// bundle that travels down the read-latency delay line.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef logic [2:0] rgb111_t;
  localparam rgb111_t RGB_BLACK   = 3'b000;
  localparam rgb111_t RGB_BLUE    = 3'b001;
  localparam rgb111_t RGB_GREEN   = 3'b010;
  localparam rgb111_t RGB_CYAN    = 3'b011;
  localparam rgb111_t RGB_RED     = 3'b100;
  localparam rgb111_t RGB_MAGENTA = 3'b101;
  localparam rgb111_t RGB_YELLOW  = 3'b110;
  localparam rgb111_t RGB_WHITE   = 3'b111;

  typedef struct packed {
    logic active;
    logic region;
    logic border;
    logic hs;
    logic vs;
    logic fs;
  } pix_flags_t;
endpackage

// File: rtl/vga_frame_reader_if.sv
// Frame-buffer RAM read port: the reader drives the address, the RAM returns data.
interface vga_frame_reader_if #(
  parameter int AW = 15,
  parameter int DW = 3
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  modport master (output mem_addr, input mem_data);
  modport slave  (input mem_addr, output mem_data);
endinterface

// File: rtl/vga_timing.sv
// Free-running 800x525 pixel/line counters with raw (undelayed) sync, active
// and frame-start decodes; everything advances only on clk_en.
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hs,
  output logic       vs,
  output logic       active,
  output logic       fs
);
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (clk_en) begin
      if (h == 10'(H_TOTAL - 1)) begin
        h <= '0;
        v <= (v == 10'(V_TOTAL - 1)) ? '0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  assign hs     = (h >= 10'(H_SYNC_START)) && (h < 10'(H_SYNC_END));
  assign vs     = (v >= 10'(V_SYNC_START)) && (v < 10'(V_SYNC_END));
  assign active = (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
  assign fs     = (h == '0) && (v == '0);
endmodule

// File: rtl/vga_frame_reader.sv
// Frame-buffer scan-out: incremental (multiplier-free) address walk, flag delay
// line matched to RAM latency, and registered VGA outputs.
// Optional frame around the image: define VGA_BORDER_EN.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int SCALE  = 1,
  parameter int DW     = 3,
  parameter int AW     = 15,
  parameter int RD_LAT = 1,
  parameter logic [DW-1:0] BG_COLOR     = '0,
  parameter logic [DW-1:0] BORDER_COLOR = {DW{1'b1}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  vga_frame_reader_if.master  mem,
  output logic                vga_hsync_n,
  output logic                vga_vsync_n,
  output logic [DW-1:0]       vga_rgb,
  output logic                frame_start
);
  localparam int REG_W = IMG_W * SCALE;
  localparam int REG_H = IMG_H * SCALE;
  localparam logic [1:0] SUB_MAX = 2'(SCALE - 1);

  generate
    if (REG_W > H_ACTIVE || REG_H > V_ACTIVE || IMG_W * IMG_H > (1 << AW)) begin : g_size_err
      $error("vga_frame_reader: image does not fit the screen or the address space");
    end
    if (SCALE != 1 && SCALE != 2 && SCALE != 4) begin : g_scale_err
      $error("vga_frame_reader: SCALE must be 1, 2 or 4");
    end
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_lat_err
      $error("vga_frame_reader: RD_LAT must be 1..3");
    end
  endgenerate

  logic [9:0] h, v;
  logic       hs, vs, active, fs;

  vga_timing u_timing (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .h      (h),
    .v      (v),
    .hs     (hs),
    .vs     (vs),
    .active (active),
    .fs     (fs)
  );

  logic region, border, line_end, last_row;
  assign region   = (h < 10'(REG_W)) && (v < 10'(REG_H));
  assign line_end = region && (h == 10'(REG_W - 1));
  assign last_row = (v == 10'(REG_H - 1));

`ifdef VGA_BORDER_EN
  assign border = ((h == 10'(REG_W)) && (v <= 10'(REG_H))) ||
                  ((v == 10'(REG_H)) && (h <= 10'(REG_W)));
`else
  assign border = 1'b0;
`endif

  // addr always holds the address of the current pixel when inside the image,
  // otherwise the next address to be fetched, so mem_addr never leaves range.
  logic [AW-1:0] addr, line_base;
  logic [1:0]    x_sub, y_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr         <= '0;
      line_base    <= '0;
      x_sub        <= '0;
      y_sub        <= '0;
      mem.mem_addr <= '0;
    end else if (clk_en) begin
      mem.mem_addr <= addr;
      if (line_end) begin
        x_sub <= '0;
        if (y_sub != SUB_MAX) begin
          addr  <= line_base;
          y_sub <= y_sub + 2'd1;
        end else if (last_row) begin
          addr      <= '0;
          line_base <= '0;
          y_sub     <= '0;
        end else begin
          addr      <= addr + AW'(1);
          line_base <= addr + AW'(1);
          y_sub     <= '0;
        end
      end else if (region) begin
        if (x_sub == SUB_MAX) begin
          x_sub <= '0;
          addr  <= addr + AW'(1);
        end else begin
          x_sub <= x_sub + 2'd1;
        end
      end
    end
  end

  pix_flags_t          cur;
  pix_flags_t          flag_pipe [RD_LAT:0];
  logic [RD_LAT:0]     vld_pipe;

  always_comb begin
    cur        = '0;
    cur.active = active;
    cur.region = region;
    cur.border = border;
    cur.hs     = hs;
    cur.vs     = vs;
    cur.fs     = fs;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else if (clk_en) vld_pipe <= {vld_pipe[RD_LAT-1:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      flag_pipe[0] <= cur;
      for (int i = 1; i <= RD_LAT; i++) flag_pipe[i] <= flag_pipe[i-1];
    end
  end

  // Tail of the delay line lines up with mem_data for the same pixel.
  pix_flags_t tail;
  logic       tail_vld;
  assign tail     = flag_pipe[RD_LAT];
  assign tail_vld = vld_pipe[RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hsync_n <= 1'b1;
      vga_vsync_n <= 1'b1;
      vga_rgb     <= '0;
      frame_start <= 1'b0;
    end else if (clk_en) begin
      vga_hsync_n <= ~(tail_vld & tail.hs);
      vga_vsync_n <= ~(tail_vld & tail.vs);
      frame_start <= tail_vld & tail.fs;
      if (!tail_vld || !tail.active) vga_rgb <= '0;
      else if (tail.region)          vga_rgb <= mem.mem_data;
      else if (tail.border)          vga_rgb <= BORDER_COLOR;
      else                           vga_rgb <= BG_COLOR;
    end
  end
endmodule
